pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard unit.
// The datapath side (master) supplies decode/execute/memory controls and
// consumes the register enables, flush/bubble strobes and status.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ewreg;
  logic             em2reg;
  logic [4:0]       edestReg;
  logic             mwmem;
  logic             mm2reg;
  logic             dmem_ready;
  logic             branch_taken;
  logic             pc_en;
  logic             ifid_en;
  logic             idexe_en;
  logic             exemem_en;
  logic             ifid_flush;
  logic             idexe_bubble;
  logic             memwb_bubble;
  logic             fault;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, ewreg, em2reg, edestReg,
           mwmem, mm2reg, dmem_ready, branch_taken,
    input  pc_en, ifid_en, idexe_en, exemem_en,
           ifid_flush, idexe_bubble, memwb_bubble, fault, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ewreg, em2reg, edestReg,
           mwmem, mm2reg, dmem_ready, branch_taken,
    output pc_en, ifid_en, idexe_en, exemem_en,
           ifid_flush, idexe_bubble, memwb_bubble, fault, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-freeze, load-use stall and branch flush
// arbitration with a memory-timeout watchdog and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic               clock,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int                WAIT_W      = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t            state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic active;
  logic mem_op;
  logic freeze;
  logic rs_hit;
  logic rt_hit;
  logic lu;
  logic stall_inc;

  logic pc_en_next;
  logic ifid_en_next;
  logic idexe_en_next;
  logic exemem_en_next;
  logic ifid_flush_next;
  logic idexe_bubble_next;
  logic memwb_bubble_next;
  logic fault_next;

  // Hazard detection; nothing is detected once the watchdog has tripped.
  assign active = (state_reg != FAULT);
  assign mem_op = bus.mwmem | bus.mm2reg;
  assign freeze = active & mem_op & ~bus.dmem_ready;
  assign rs_hit = (bus.edestReg == bus.id_rs);
  assign rt_hit = bus.id_uses_rt & (bus.edestReg == bus.id_rt);
  assign lu     = active & bus.em2reg & bus.ewreg & (bus.edestReg != 5'd0) & (rs_hit | rt_hit);

  // Both freeze and load-use hold the PC, so either one is a stalled cycle.
  assign stall_inc = freeze | lu;

  // wait_cnt holds the number of freeze cycles already completed, so this
  // value is the length of the run including the current freeze cycle.
  assign wait_cnt_next = wait_cnt_reg + 1'b1;

  // Output priority: fault > freeze > load-use > branch > normal.
  always_comb begin
    pc_en_next        = 1'b0;
    ifid_en_next      = 1'b0;
    idexe_en_next     = 1'b0;
    exemem_en_next    = 1'b0;
    ifid_flush_next   = 1'b0;
    idexe_bubble_next = 1'b0;
    memwb_bubble_next = 1'b0;
    fault_next        = 1'b0;
    if (reset) begin
      // everything held off while reset is asserted
    end else if (!active) begin
      fault_next = 1'b1;
    end else if (freeze) begin
      memwb_bubble_next = 1'b1;
    end else if (lu) begin
      // The branch in ID is stalled too and re-resolves next cycle.
      idexe_en_next     = 1'b1;
      exemem_en_next    = 1'b1;
      idexe_bubble_next = 1'b1;
    end else begin
      pc_en_next      = 1'b1;
      ifid_en_next    = 1'b1;
      idexe_en_next   = 1'b1;
      exemem_en_next  = 1'b1;
      ifid_flush_next = bus.branch_taken;
    end
  end

  assign bus.pc_en        = pc_en_next;
  assign bus.ifid_en      = ifid_en_next;
  assign bus.idexe_en     = idexe_en_next;
  assign bus.exemem_en    = exemem_en_next;
  assign bus.ifid_flush   = ifid_flush_next;
  assign bus.idexe_bubble = idexe_bubble_next;
  assign bus.memwb_bubble = memwb_bubble_next;
  assign bus.fault        = fault_next;
  assign bus.stall_cycles = stall_cnt_reg;

  // Watchdog state machine and saturating stall statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (freeze) begin
            state_reg    <= MWAIT;
            wait_cnt_reg <= WAIT_W'(1);
          end
        end
        MWAIT: begin
          if (freeze) begin
            if (wait_cnt_next == TIMEOUT_CNT) begin
              state_reg    <= FAULT;
              wait_cnt_reg <= '0;
            end else begin
              wait_cnt_reg <= wait_cnt_next;
            end
          end else begin
            // A completed access releases the pipe; no state carries over.
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
          end
        end
        FAULT: begin
          state_reg <= FAULT;
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= '0;
        end
      endcase
      if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

endmodule
